ahb_apb_bridge_param: RTL and testbench
=======================================

AHB_APB_BRIDGE_PARAM -- requirements
Module: ahb_apb_bridge_param

Interface
REQ-001 Parameters, each given as name, default, meaning:
- NUM_SLV, 8, number of APB slave slots (1..16).
- PADDR_W, 12, APB address width; each slot decodes 2^PADDR_W bytes.
- TIMEOUT, 255, cycles of PREADY low before forced error (1..65535).

REQ-002 Ports, each given as name, direction, width, meaning:
- HCLK  in  1  clock; all logic rising-edge.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  bridge selected.
- HADDR  in  PADDR_W+4  byte address; [PADDR_W+3:PADDR_W] is the slot index.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write.
- HNONSEC  in  1  non-secure.
- HPROT  in  7  protection.
- HREADY  in  1  bus ready.
- HWDATA  in  32  write data.
- HREADYOUT  out  1  bridge ready.
- HRDATA  out  32  read data.
- HRESP  out  1  error.
- PADDR  out  PADDR_W  APB address, [1:0] forced 0.
- PENABLE, PWRITE  out  1 each  APB control.
- PPROT  out  3  {~HPROT[0], HNONSEC, HPROT[1]}.
- PSTRB  out  4  byte strobes.
- PWDATA  out  32  write data.
- PSEL  out  NUM_SLV  one-hot select.
- PRDATA_ALL  in  NUM_SLV*32  slot k at [32k+31:32k].
- PREADY_ALL, PSLVERR_ALL  in  NUM_SLV  per-slot ready and error.

Function
REQ-003 The bridge SHALL accept a transfer when HSEL & HREADY & HTRANS[1], capturing address, control, PPROT and slot index.
REQ-004 The FSM SHALL have the states IDLE, WDATA, SETUP, ACCESS, ERR1 and ERR2.
REQ-005 For an accepted transfer to slot < NUM_SLV, the FSM SHALL go IDLE->WDATA; in WDATA, HWDATA is latched into PWDATA and HREADYOUT=0.
REQ-006 From WDATA the FSM SHALL go to SETUP, which drives PSEL[idx]=1 and PENABLE=0 for exactly 1 cycle.
REQ-007 From SETUP the FSM SHALL go to ACCESS, which drives PSEL[idx]=1 and PENABLE=1 and holds until PREADY_ALL[idx]=1.
REQ-008 On ACCESS with PREADY=1 and PSLVERR=0, HREADYOUT SHALL be 1 and HRDATA SHALL be the registered PRDATA of the slot, and the FSM SHALL return to IDLE; minimum transfer latency is 4 cycles of HREADYOUT low-to-high from the address phase.
REQ-009 On ACCESS with PREADY=1 and PSLVERR=1, or on an accepted transfer with slot index >= NUM_SLV, the FSM SHALL give a two-cycle AHB error response:
- ERR1: HRESP=1, HREADYOUT=0.
- ERR2: HRESP=1, HREADYOUT=1.
- An out-of-range slot SHALL assert no PSEL bit.
REQ-010 PSTRB SHALL be 0 for reads; for writes it SHALL follow HSIZE and HADDR[1:0]: byte gives one bit, halfword gives 2'b11 shifted by HADDR[1], word gives 4'hF.
REQ-011 Outside SETUP and ACCESS, PSEL and PENABLE SHALL be 0; PADDR, PWDATA and PSTRB SHALL hold their last values.
REQ-012 HRDATA SHALL be 0 except in the completing cycle of a read.
REQ-013 In IDLE and ERR2, HREADYOUT SHALL be 1; IDLE/ERR2 accept a new transfer in the same cycle (back-to-back).
REQ-014 IDLE transfers (HTRANS=00) and BUSY transfers (HTRANS=01) SHALL receive an OKAY response with zero wait states.

Reset
REQ-015 While HRESET=1 at a rising HCLK edge, the FSM SHALL go to IDLE.
REQ-016 While HRESET=1, the outputs SHALL be: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, and the timeout counter SHALL be 0.
REQ-017 A reset mid-transfer SHALL abort the transfer with PSEL deasserted the next cycle; no response is owed.

Configuration
REQ-018 With APB_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
- When the counter reaches TIMEOUT, the bridge SHALL deassert PSEL/PENABLE and enter ERR1.
- A late PREADY from the slave SHALL then be ignored.
REQ-019 Without APB_TIMEOUT_EN, there SHALL be no counter and ACCESS SHALL wait indefinitely.

Structure
REQ-020 The package ahb_apb_pkg SHALL hold the FSM state enum, the HTRANS encodings, the HSIZE encodings and the PSTRB decode function.
REQ-021 The sub-module apb_slot_mux SHALL select PRDATA/PREADY/PSLVERR by registered index.
REQ-022 NUM_SLV/PADDR_W legality SHALL be checked at elaboration.

Verification
REQ-023 Word write 0xDEADBEEF to slot 2, offset 0x10 -> PSEL=0x04, PADDR=0x010, PSTRB=0xF, PWDATA=0xDEADBEEF in SETUP, then 1 ACCESS cycle; HREADYOUT high 4 cycles after the address phase.
REQ-024 Byte read at offset 0x3 of slot 0 with the slave inserting 3 wait states -> PSTRB=0, ACCESS lasts 4 cycles, and HRDATA equals the slave data in the completing cycle only.
REQ-025 Slave asserts PSLVERR on a write -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then IDLE.
REQ-026 With NUM_SLV=5, access slot 6 -> PSEL stays 0 and a two-cycle error response is given.
REQ-027 With APB_TIMEOUT_EN and TIMEOUT=8, PREADY held low -> error response begins after 8 ACCESS cycles; without the macro, the bench must show the bridge still waiting at cycle 100.
REQ-028 Reset asserted in ACCESS, then two back-to-back writes after reset -> clean reset values, and both writes complete in order with correct PSTRB.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared FSM state type, AHB encodings and the APB strobe decode for the AHB-to-APB bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY get a zero-wait OKAY.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

  function automatic logic [3:0] pstrb_decode(input logic       write,
                                              input logic [2:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'h0;
    if (write) begin
      case (size)
        HSIZE_BYTE: strb = 4'b0001 << addr_lo;
        HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        HSIZE_WORD: strb = 4'hF;
        default:    strb = 4'hF;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/apb_slot_mux.sv
// Selects PRDATA/PREADY/PSLVERR of the addressed APB slot.
// Latency: combinational. Backpressure: none, pure select; unknown slot returns all zeros.
module apb_slot_mux #(
  parameter int NUM_SLV = 8
) (
  input  logic [3:0]           slot_idx,
  input  logic [NUM_SLV*32-1:0] prdata_all,
  input  logic [NUM_SLV-1:0]   pready_all,
  input  logic [NUM_SLV-1:0]   pslverr_all,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr
);

  always_comb begin
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (slot_idx == 4'(k)) begin
        prdata  = prdata_all[k*32 +: 32];
        pready  = pready_all[k];
        pslverr = pslverr_all[k];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// AHB-lite to APB bridge over NUM_SLV slots; `define APB_TIMEOUT_EN adds a PREADY watchdog.
// Latency: HREADYOUT returns 4 cycles after the address phase for a zero-wait slave, +1 per wait state.
// Backpressure: HREADYOUT low while a transfer is in flight; errors answered with a two-cycle ERROR.
module ahb_apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLV = 8,
  parameter int PADDR_W = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [PADDR_W+3:0]      HADDR,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic                    HWRITE,
  input  logic                    HNONSEC,
  input  logic [6:0]              HPROT,
  input  logic                    HREADY,
  input  logic [31:0]             HWDATA,
  output logic                    HREADYOUT,
  output logic [31:0]             HRDATA,
  output logic                    HRESP,
  output logic [PADDR_W-1:0]      PADDR,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [2:0]              PPROT,
  output logic [3:0]              PSTRB,
  output logic [31:0]             PWDATA,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV*32-1:0]   PRDATA_ALL,
  input  logic [NUM_SLV-1:0]      PREADY_ALL,
  input  logic [NUM_SLV-1:0]      PSLVERR_ALL
);

  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("ahb_apb_bridge_param: NUM_SLV must be 1..16");
  end
  if (PADDR_W < 3 || PADDR_W > 28) begin : g_bad_paddr_w
    $error("ahb_apb_bridge_param: PADDR_W must be 3..28");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ahb_apb_bridge_param: TIMEOUT must be 1..65535");
  end

  state_t               state;
  logic [3:0]           slot_idx;
  logic [PADDR_W-1:0]   addr_q;
  logic [2:0]           size_q;
  logic                 write_q;
  logic [2:0]           pprot_q;
  logic [31:0]          prdata_sel;
  logic                 pready_sel;
  logic                 pslverr_sel;
  logic [3:0]           haddr_slot;
  logic                 accept;
  logic                 unused_hprot;

`ifdef APB_TIMEOUT_EN
  logic [15:0]          to_cnt;
`endif

  assign haddr_slot   = HADDR[PADDR_W+3:PADDR_W];
  assign accept       = HSEL && HREADY && htrans_active(HTRANS);
  assign unused_hprot = &{1'b0, HPROT[6:2]};

  apb_slot_mux #(.NUM_SLV(NUM_SLV)) u_slot_mux (
    .slot_idx    (slot_idx),
    .prdata_all  (PRDATA_ALL),
    .pready_all  (PREADY_ALL),
    .pslverr_all (PSLVERR_ALL),
    .prdata      (prdata_sel),
    .pready      (pready_sel),
    .pslverr     (pslverr_sel)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      slot_idx  <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      pprot_q   <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      HRDATA <= '0;
      case (state)
        // ERR2 already shows HREADYOUT=1, so the master may start the next transfer here.
        ST_IDLE, ST_ERR2: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          state     <= ST_IDLE;
          if (accept) begin
            slot_idx  <= haddr_slot;
            addr_q    <= HADDR[PADDR_W-1:0];
            size_q    <= HSIZE;
            write_q   <= HWRITE;
            pprot_q   <= {~HPROT[0], HNONSEC, HPROT[1]};
            HREADYOUT <= 1'b0;
            if ({1'b0, haddr_slot} < 5'(NUM_SLV)) begin
              state <= ST_WDATA;
            end else begin
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end
          end
        end
        // APB-side outputs only move when SETUP begins, so they hold between transfers.
        ST_WDATA: begin
          PWDATA  <= HWDATA;
          PADDR   <= {addr_q[PADDR_W-1:2], 2'b00};
          PWRITE  <= write_q;
          PPROT   <= pprot_q;
          PSTRB   <= pstrb_decode(write_q, size_q, addr_q[1:0]);
          PSEL    <= NUM_SLV'(1) << slot_idx;
          PENABLE <= 1'b0;
          state   <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (pslverr_sel) begin
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              HRDATA    <= write_q ? '0 : prdata_sel;
              state     <= ST_IDLE;
            end
          end
`ifdef APB_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
            // Dropping PSEL here makes any late PREADY from the slave irrelevant.
            if (to_cnt == 16'(TIMEOUT - 1)) begin
              PSEL    <= '0;
              PENABLE <= 1'b0;
              HRESP   <= 1'b1;
              state   <= ST_ERR1;
            end
          end
`endif
        end
        ST_ERR1: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
          state     <= ST_ERR2;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Self-checking bench for ahb_apb_bridge_param with 5 slots; APB transfers checked against a queue.
module tb_ahb_apb_bridge_param;

  localparam int NS = 5;
  localparam int AW = 12;
  localparam int TO = 8;

  logic              HCLK = 1'b0;
  logic              HRESET, HSEL, HWRITE, HNONSEC, HREADY;
  logic [AW+3:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [6:0]        HPROT;
  logic [31:0]       HWDATA;
  logic              HREADYOUT, HRESP;
  logic [31:0]       HRDATA;
  logic [AW-1:0]     PADDR;
  logic              PENABLE, PWRITE;
  logic [2:0]        PPROT;
  logic [3:0]        PSTRB;
  logic [31:0]       PWDATA;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA_ALL;
  logic [NS-1:0]     PREADY_ALL, PSLVERR_ALL;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_apb_bridge_param #(.NUM_SLV(NS), .PADDR_W(AW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HNONSEC(HNONSEC), .HPROT(HPROT), .HREADY(HREADY),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB),
    .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA_ALL(PRDATA_ALL), .PREADY_ALL(PREADY_ALL),
    .PSLVERR_ALL(PSLVERR_ALL)
  );

  // Slave model: ready after ws wait states unless hung, optional error.
  int   ws = 0;
  int   acc_cnt = 0;
  logic hang = 1'b0;
  logic slv_err = 1'b0;
  logic slv_rdy;

  function automatic logic [31:0] slot_data(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  for (genvar k = 0; k < NS; k++) begin : g_slv
    assign PRDATA_ALL[k*32 +: 32] = slot_data(k);
  end

  assign slv_rdy     = PENABLE && (acc_cnt >= ws) && !hang;
  assign PREADY_ALL  = slv_rdy ? PSEL : '0;
  assign PSLVERR_ALL = (slv_rdy && slv_err) ? PSEL : '0;

  always @(posedge HCLK) acc_cnt <= (PENABLE && !slv_rdy) ? acc_cnt + 1 : 0;

  typedef struct {
    logic [NS-1:0] psel;
    logic [AW-1:0] paddr;
    logic [3:0]    pstrb;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [2:0]    pprot;
  } apb_exp_t;

  apb_exp_t      exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_obs = 0;
  logic          psel_seen = 1'b0;
  logic          mon_en = 1'b0;
  logic [NS-1:0] cur_psel = '0;

  always @(negedge HCLK) begin
    if (mon_en) begin : mon
      apb_exp_t e;
      if (|PSEL) psel_seen = 1'b1;
      checks++;
      if (PENABLE && PSEL == '0) begin
        errors++; $display("FAIL penable_idle PENABLE=%b PSEL=%b required PENABLE=0", PENABLE, PSEL);
      end
      if (|PSEL && !PENABLE) begin
        acc_obs = 0;
        cur_psel = PSEL;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL apb_unexpected PSEL=%b PADDR=%h required no transfer", PSEL, PADDR);
        end else begin
          e = exp_q.pop_front();
          if (PSEL !== e.psel || PADDR !== e.paddr || PSTRB !== e.pstrb || PWRITE !== e.pwrite ||
              PPROT !== e.pprot || (e.pwrite && PWDATA !== e.pwdata)) begin
            errors++;
            $display("FAIL apb_setup got psel=%b paddr=%h pstrb=%h pwrite=%b pprot=%b pwdata=%h required psel=%b paddr=%h pstrb=%h pwrite=%b pprot=%b pwdata=%h",
                     PSEL, PADDR, PSTRB, PWRITE, PPROT, PWDATA, e.psel, e.paddr, e.pstrb, e.pwrite, e.pprot, e.pwdata);
          end
        end
      end else if (|PSEL && PENABLE) begin
        acc_obs++;
        checks++;
        if (PSEL !== cur_psel) begin
          errors++; $display("FAIL apb_access_psel got %b required %b", PSEL, cur_psel);
        end
      end
    end
  end

  task automatic start(input logic wr, input logic [AW+3:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
  endtask

  // Returns at the negedge of the completing cycle; lat counts from the address phase.
  task automatic wait_done(output logic [31:0] rd, output logic rsp, output int lat,
                           output logic err1, output logic early_rd);
    lat = 1; err1 = 1'b0; early_rd = 1'b0;
    while (!HREADYOUT && lat < 300) begin
      err1 = HRESP;
      if (HRDATA !== 32'h0) early_rd = 1'b1;
      @(negedge HCLK);
      lat++;
    end
    rd = HRDATA; rsp = HRESP;
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++; $display("FAIL wait_done_timeout HREADYOUT=%b after %0d cycles required 1", HREADYOUT, lat);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b required 1", HREADYOUT); end
    checks++;
    if ({HRESP, HRDATA, PSEL, PENABLE} !== '0) begin
      errors++; $display("FAIL reset_ctrl got hresp=%b hrdata=%h psel=%b penable=%b required all 0", HRESP, HRDATA, PSEL, PENABLE);
    end
    checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== '0) begin
      errors++; $display("FAIL reset_apb got pwrite=%b paddr=%h pwdata=%h pstrb=%h pprot=%b required all 0", PWRITE, PADDR, PWDATA, PSTRB, PPROT);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_word_write();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    HNONSEC = 1'b1;
    exp_q.push_back('{5'b00100, 12'h010, 4'hF, 1'b1, 32'hDEADBEEF, 3'b011});
    start(1'b1, 16'h2010, 3'b010, 32'hDEADBEEF);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ww_latency got %0d required 4", lat); end
    checks++; if (rsp !== 1'b0) begin errors++; $display("FAIL ww_hresp got %b required 0", rsp); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ww_hrdata got %h required 0", rd); end
    checks++; if (acc_obs !== 1) begin errors++; $display("FAIL ww_access_cycles got %0d required 1", acc_obs); end
    @(negedge HCLK);
    checks++;
    if (PSEL !== '0 || PADDR !== 12'h010 || PWDATA !== 32'hDEADBEEF || PSTRB !== 4'hF) begin
      errors++; $display("FAIL ww_hold got psel=%b paddr=%h pwdata=%h pstrb=%h required 0/010/deadbeef/f", PSEL, PADDR, PWDATA, PSTRB);
    end
    HNONSEC = 1'b0;
  endtask

  task automatic test_byte_read_wait();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    ws = 3;
    exp_q.push_back('{5'b00001, 12'h000, 4'h0, 1'b0, 32'h0, 3'b001});
    start(1'b0, 16'h0003, 3'b000, 32'h0);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (acc_obs !== 4) begin errors++; $display("FAIL rd_access_cycles got %0d required 4", acc_obs); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL rd_latency got %0d required 7", lat); end
    checks++; if (rd !== 32'h5A00_0000) begin errors++; $display("FAIL rd_data got %h required 5a000000", rd); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL rd_early_hrdata got %b required 0", early); end
    checks++; if (rsp !== 1'b0) begin errors++; $display("FAIL rd_hresp got %b required 0", rsp); end
    @(negedge HCLK);
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rd_hrdata_after got %h required 0", HRDATA); end
    ws = 0;
  endtask

  task automatic test_slverr_write();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    slv_err = 1'b1;
    exp_q.push_back('{5'b00010, 12'h040, 4'hF, 1'b1, 32'h0BAD_F00D, 3'b001});
    start(1'b1, 16'h1040, 3'b010, 32'h0BAD_F00D);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL slverr_err1 got hresp=%b required 1", err1); end
    checks++; if (rsp !== 1'b1) begin errors++; $display("FAIL slverr_err2 got hresp=%b required 1", rsp); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL slverr_latency got %0d required 5", lat); end
    @(negedge HCLK);
    checks++;
    if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
      errors++; $display("FAIL slverr_idle got hresp=%b hreadyout=%b required 0/1", HRESP, HREADYOUT);
    end
    slv_err = 1'b0;
  endtask

  task automatic test_bad_slot();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    psel_seen = 1'b0;
    start(1'b0, 16'h6000, 3'b010, 32'h0);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bad_slot_latency got %0d required 2", lat); end
    checks++; if ({err1, rsp} !== 2'b11) begin errors++; $display("FAIL bad_slot_resp got err1=%b err2=%b required 1/1", err1, rsp); end
    checks++; if (psel_seen !== 1'b0) begin errors++; $display("FAIL bad_slot_psel got psel seen required none"); end
  endtask

  task automatic test_idle_busy();
    for (int t = 0; t < 2; t++) begin
      HSEL = 1'b1; HTRANS = 2'(t); HADDR = 16'h2000;
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== '0) begin
        errors++; $display("FAIL idle_busy_%0d got hreadyout=%b hresp=%b psel=%b required 1/0/0", t, HREADYOUT, HRESP, PSEL);
      end
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    hang = 1'b1;
    exp_q.push_back('{5'b01000, 12'h008, 4'h0, 1'b0, 32'h0, 3'b001});
    start(1'b0, 16'h3008, 3'b010, 32'h0);
`ifdef APB_TIMEOUT_EN
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (acc_obs !== TO) begin errors++; $display("FAIL to_access_cycles got %0d required %0d", acc_obs, TO); end
    checks++; if ({err1, rsp} !== 2'b11) begin errors++; $display("FAIL to_resp got err1=%b err2=%b required 1/1", err1, rsp); end
    checks++; if (lat !== TO + 4) begin errors++; $display("FAIL to_latency got %0d required %0d", lat, TO + 4); end
    hang = 1'b0;
    @(negedge HCLK);
    checks++;
    if (HRESP !== 1'b0 || PSEL !== '0) begin
      errors++; $display("FAIL to_late_pready got hresp=%b psel=%b required 0/0", HRESP, PSEL);
    end
`else
    repeat (99) @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0 || PSEL !== 5'b01000 || PENABLE !== 1'b1) begin
      errors++; $display("FAIL no_to_waiting got hreadyout=%b psel=%b penable=%b required 0/01000/1", HREADYOUT, PSEL, PENABLE);
    end
    hang = 1'b0;
    wait_done(rd, rsp, lat, err1, early);
    checks++;
    if (rsp !== 1'b0 || rd !== 32'h5A03_0303) begin
      errors++; $display("FAIL no_to_complete got hresp=%b hrdata=%h required 0/5a030303", rsp, rd);
    end
`endif
    hang = 1'b0;
  endtask

  task automatic test_reset_back_to_back();
    logic [31:0] rd; logic rsp, err1, early; int lat;
    hang = 1'b1;
    exp_q.push_back('{5'b10000, 12'h0FC, 4'hF, 1'b1, 32'hCAFE_0001, 3'b001});
    start(1'b1, 16'h40FC, 3'b010, 32'hCAFE_0001);
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge HCLK);
    checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rst_mid_access got penable=%b required 1", PENABLE); end
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if (PSEL !== '0 || PENABLE !== 1'b0) begin errors++; $display("FAIL rst_mid_psel got psel=%b penable=%b required 0/0", PSEL, PENABLE); end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL rst_mid_ahb got hreadyout=%b hresp=%b required 1/0", HREADYOUT, HRESP); end
    checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== '0) begin
      errors++; $display("FAIL rst_mid_apb got pwrite=%b paddr=%h pwdata=%h pstrb=%h pprot=%b required all 0", PWRITE, PADDR, PWDATA, PSTRB, PPROT);
    end
    hang = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    exp_q.push_back('{5'b00010, 12'h020, 4'b1100, 1'b1, 32'h1234_5678, 3'b001});
    exp_q.push_back('{5'b01000, 12'h104, 4'b0010, 1'b1, 32'hAABB_CCDD, 3'b001});
    start(1'b1, 16'h1022, 3'b001, 32'h1234_5678);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (lat !== 4 || rsp !== 1'b0) begin errors++; $display("FAIL b2b_first got lat=%0d hresp=%b required 4/0", lat, rsp); end
    start(1'b1, 16'h3105, 3'b000, 32'hAABB_CCDD);
    wait_done(rd, rsp, lat, err1, early);
    checks++; if (lat !== 4 || rsp !== 1'b0) begin errors++; $display("FAIL b2b_second got lat=%0d hresp=%b required 4/0", lat, rsp); end
    @(negedge HCLK);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'b000;
    HPROT = 7'b0000011; HNONSEC = 1'b0; HWDATA = '0;
    test_reset();
    mon_en = 1'b1;
    test_word_write();
    test_byte_read_wait();
    test_slverr_write();
    test_bad_slot();
    test_idle_busy();
    test_timeout();
    test_reset_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
